svm_matmul2_accum: RTL and testbench
====================================

// Module: svm_matmul2_accum
// PURPOSE
// - Second-matmul producer for the ROM/systolic SVM. Accumulates one frame of SUP_WIDTH kernel values
//   against per-support-vector valence and arousal coefficients from the coefficient ROM.
// - Drives the decision stage's serial result bus: valence sum with matmul2_v_valid, then arousal sum
//   with matmul2_a_valid on the next cycle. The decision stage never back-pressures, so there is no ready on that side.
// PARAMETERS
// - NBITS          16  coefficient width (signed)
// - LOG_F_WIDTH    10  growth bits of first-matmul kernel values; KW = NBITS+LOG_F_WIDTH
// - SUP_WIDTH      64  support vectors per frame (>=2)
// - LOG_SUP_WIDTH  6   clog2(SUP_WIDTH); RES_W = 2*NBITS+LOG_F_WIDTH+LOG_SUP_WIDTH
// PORTS
// - clk              in   1              single clock, rising edge
// - rst              in   1              synchronous, active-low reset (0 = reset)
// - din              in   KW             signed kernel value for support vector coef_addr
// - din_valid        in   1              upstream valid
// - din_ready        out  1              high only in ACCUM; fire = din_valid && din_ready
// - coef_addr        out  LOG_SUP_WIDTH  ROM address = element index; ROM read latency 1 cycle
// - v_coef           in   NBITS          signed valence coefficient, data for last cycle's coef_addr
// - a_coef           in   NBITS          signed arousal coefficient, data for last cycle's coef_addr
// - matmul2_result   out  RES_W          signed dot product; valence in EMIT_V, arousal in EMIT_A
// - matmul2_v_valid  out  1              one-cycle pulse: result holds the valence sum
// - matmul2_a_valid  out  1              one-cycle pulse: result holds the arousal sum
// BEHAVIOUR
// - FSM states: ACCUM -> DRAIN -> EMIT_V -> EMIT_A -> ACCUM. Each non-ACCUM state lasts exactly 1 cycle.
// - ACCUM:
//   - din_ready=1; coef_addr=idx.
//   - On fire: din -> din_q, mac_v=1, idx++.
//   - Fire with idx==SUP_WIDTH-1: idx->0, go to DRAIN.
//   - No fire: idx and coef_addr hold, mac_v=0. Bubbles are legal.
// - MAC stage (cycle after a fire, mac_v=1): v_acc += din_q*v_coef; a_acc += din_q*a_coef.
//   - Each product is signed KW x NBITS; sign-extend to RES_W.
//   - Two's-complement add, no saturation; RES_W covers SUP_WIDTH worst-case terms.
// - DRAIN: din_ready=0; the last element's MAC completes.
// - EMIT_V: matmul2_result=v_acc, matmul2_v_valid=1.
// - EMIT_A: matmul2_result=a_acc, matmul2_a_valid=1; both accumulators clear to 0 at the end of this cycle.
// - Latency: last fire at cycle t -> v_valid at t+2, a_valid at t+3, din_ready high again at t+4.
//   Throughput: one frame per SUP_WIDTH+3 cycles when din_valid is held high.
// - Outputs are registered (from state/accumulators), with no combinational path from din/din_valid.
//   matmul2_result=0 outside EMIT_V/EMIT_A. v_valid and a_valid are never high together.
// - Reset (rst==0 at edge):
//   - state=ACCUM; idx, mac_v, accumulators, matmul2_result=0; v_valid=a_valid=0.
//   - din_ready=0 while rst==0, 1 from the first cycle after release.
//   - Reset mid-frame or mid-emit discards the partial frame. No pulse is emitted for it.
// - din and coef values are ignored unless mac_v/fire qualify them; X on unqualified inputs must not propagate.
// STRUCTURE
// - svm_pkg holds: state enum svm_m2_state_t {ACCUM,DRAIN,EMIT_V,EMIT_A}, and width helpers KW/RES_W as
//   localparam functions of NBITS/LOG_F_WIDTH/LOG_SUP_WIDTH, shared with the decision stage.
// - Sub-module svm_mac: signed multiply-accumulate with synchronous clear and enable, parameterised by
//   KW/NBITS/RES_W. Instantiated twice (valence, arousal). Top level holds FSM, idx counter, din_q/mac_v.
// TESTING (bench model: 1-cycle registered ROM; SUP_WIDTH=4 unless noted)
// - Basic: din=1 x4, v_coef=[1,2,3,4], a_coef=-1 all -> result=10 with v_valid at t+2, result=-4 with a_valid at t+3.
// - Extremes: din=-2^(KW-1), v_coef=-2^(NBITS-1), all 4 -> result=+4*2^(KW+NBITS-2), exact, no wrap.
//   Same din with v_coef=+2^(NBITS-1)-1 -> correct negative sum.
// - Bubbles: din_valid toggling 1,0,0,1,... -> coef_addr holds across gaps; sums identical to the basic case.
// - Back-to-back: din_valid held high for 2 frames -> din_ready low exactly 3 cycles between frames;
//   frame 2 sums exclude frame 1 (accumulators cleared).
// - Reset mid-frame: rst=0 after 2 fires, release, send the basic frame -> results 10/-4; no pulse for the aborted frame.
// - Protocol: assert v_valid/a_valid are one-cycle, never concurrent, a_valid always 1 cycle after v_valid,
//   and din_ready==0 in DRAIN/EMIT_V/EMIT_A.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and width helpers for the SVM second-matmul producer and decision stage.
package svm_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    EMIT_V = 2'd2,
    EMIT_A = 2'd3
  } svm_m2_state_t;

  function automatic int svm_kw(input int nbits, input int log_f_width);
    return nbits + log_f_width;
  endfunction

  function automatic int svm_res_w(input int nbits, input int log_f_width, input int log_sup_width);
    return 2 * nbits + log_f_width + log_sup_width;
  endfunction

  localparam int SVM_NBITS_DEF         = 16;
  localparam int SVM_LOG_F_WIDTH_DEF   = 10;
  localparam int SVM_LOG_SUP_WIDTH_DEF = 6;
  localparam int SVM_KW_DEF    = svm_kw(SVM_NBITS_DEF, SVM_LOG_F_WIDTH_DEF);
  localparam int SVM_RES_W_DEF = svm_res_w(SVM_NBITS_DEF, SVM_LOG_F_WIDTH_DEF, SVM_LOG_SUP_WIDTH_DEF);

endpackage

// File: rtl/svm_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// o_sum is the accumulator value including this cycle's term when enabled.
module svm_mac
  import svm_pkg::*;
#(
  parameter int KW    = SVM_KW_DEF,
  parameter int NBITS = SVM_NBITS_DEF,
  parameter int RES_W = SVM_RES_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [KW-1:0]    i_a,
  input  logic signed [NBITS-1:0] i_b,
  output logic signed [RES_W-1:0] o_sum
);

  localparam int PW = KW + NBITS;

  logic signed [PW-1:0]    w_prod;
  logic signed [RES_W-1:0] w_prod_ext;
  logic signed [RES_W-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(RES_W - PW){w_prod[PW-1]}}, w_prod};
  // Operands are only looked at when enabled, so unqualified X cannot leak into the sum.
  assign o_sum      = i_en ? (r_acc + w_prod_ext) : r_acc;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/svm_matmul2_accum.sv
// Second-matmul producer: accumulates one frame of kernel values against valence/arousal
// coefficients and emits both sums serially to the decision stage.
//
//   state  | meaning
//   ACCUM  | accepting din, one MAC per fire, coef_addr = element index
//   DRAIN  | last element's MAC completes, din_ready low
//   EMIT_V | matmul2_result = valence sum, matmul2_v_valid high
//   EMIT_A | matmul2_result = arousal sum, matmul2_a_valid high, accumulators clear
module svm_matmul2_accum
  import svm_pkg::*;
#(
  parameter int NBITS         = 16,
  parameter int LOG_F_WIDTH   = 10,
  parameter int SUP_WIDTH     = 64,
  parameter int LOG_SUP_WIDTH = 6,
  localparam int KW    = svm_kw(NBITS, LOG_F_WIDTH),
  localparam int RES_W = svm_res_w(NBITS, LOG_F_WIDTH, LOG_SUP_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [KW-1:0]     din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [LOG_SUP_WIDTH-1:0] coef_addr,
  input  logic signed [NBITS-1:0]  v_coef,
  input  logic signed [NBITS-1:0]  a_coef,
  output logic signed [RES_W-1:0]  matmul2_result,
  output logic                     matmul2_v_valid,
  output logic                     matmul2_a_valid
);

  localparam logic [LOG_SUP_WIDTH-1:0] LAST_IDX = LOG_SUP_WIDTH'(SUP_WIDTH - 1);

  svm_m2_state_t              r_state;
  logic [LOG_SUP_WIDTH-1:0]   r_idx;
  logic signed [KW-1:0]       r_din_q;
  logic                       r_mac_v;
  logic                       r_ready;
  logic signed [RES_W-1:0]    r_result;
  logic                       r_v_valid;
  logic                       r_a_valid;

  logic                       w_fire;
  logic                       w_clr;
  logic signed [RES_W-1:0]    w_v_sum;
  logic signed [RES_W-1:0]    w_a_sum;

  assign w_fire = din_valid && r_ready;
  assign w_clr  = (r_state == EMIT_A);

  svm_mac #(.KW(KW), .NBITS(NBITS), .RES_W(RES_W)) u_mac_v (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (r_mac_v),
    .i_a   (r_din_q),
    .i_b   (v_coef),
    .o_sum (w_v_sum)
  );

  svm_mac #(.KW(KW), .NBITS(NBITS), .RES_W(RES_W)) u_mac_a (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (r_mac_v),
    .i_a   (r_din_q),
    .i_b   (a_coef),
    .o_sum (w_a_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ACCUM;
      r_idx     <= '0;
      r_din_q   <= '0;
      r_mac_v   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_v_valid <= 1'b0;
      r_a_valid <= 1'b0;
    end else begin
      r_mac_v   <= w_fire;
      r_result  <= '0;
      r_v_valid <= 1'b0;
      r_a_valid <= 1'b0;
      if (w_fire) begin
        r_din_q <= din;
      end
      case (r_state)
        ACCUM: begin
          r_ready <= 1'b1;
          if (w_fire) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= DRAIN;
              r_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        // Result is registered here from the valence sum that includes the final MAC term.
        DRAIN: begin
          r_state   <= EMIT_V;
          r_result  <= w_v_sum;
          r_v_valid <= 1'b1;
        end
        EMIT_V: begin
          r_state   <= EMIT_A;
          r_result  <= w_a_sum;
          r_a_valid <= 1'b1;
        end
        EMIT_A: begin
          r_state <= ACCUM;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ACCUM;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready       = r_ready;
  assign coef_addr       = r_idx;
  assign matmul2_result  = r_result;
  assign matmul2_v_valid = r_v_valid;
  assign matmul2_a_valid = r_a_valid;

endmodule

// File: tb/tb_svm_matmul2_accum.sv
// Scoreboard bench for svm_matmul2_accum with SUP_WIDTH=4 and a 1-cycle registered coefficient ROM.
module tb_svm_matmul2_accum;

  localparam int NBITS   = 16;
  localparam int LOG_F   = 10;
  localparam int SUP     = 4;
  localparam int LOG_SUP = 2;
  localparam int KW      = NBITS + LOG_F;
  localparam int RES_W   = 2 * NBITS + LOG_F + LOG_SUP;

  logic                    clk;
  logic                    rst;
  logic signed [KW-1:0]    din;
  logic                    din_valid;
  logic                    din_ready;
  logic [LOG_SUP-1:0]      coef_addr;
  logic signed [NBITS-1:0] v_coef;
  logic signed [NBITS-1:0] a_coef;
  logic signed [RES_W-1:0] matmul2_result;
  logic                    matmul2_v_valid;
  logic                    matmul2_a_valid;

  svm_matmul2_accum #(
    .NBITS(NBITS), .LOG_F_WIDTH(LOG_F), .SUP_WIDTH(SUP), .LOG_SUP_WIDTH(LOG_SUP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .coef_addr       (coef_addr),
    .v_coef          (v_coef),
    .a_coef          (a_coef),
    .matmul2_result  (matmul2_result),
    .matmul2_v_valid (matmul2_v_valid),
    .matmul2_a_valid (matmul2_a_valid)
  );

  // Coefficient ROM with one cycle of read latency
  logic signed [NBITS-1:0] vrom [SUP];
  logic signed [NBITS-1:0] arom [SUP];
  always @(posedge clk) begin
    v_coef <= vrom[coef_addr];
    a_coef <= arom[coef_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit     is_a;
    longint val;
  } exp_t;

  exp_t exp_q[$];
  int   lastfire_q[$];

  logic signed [KW-1:0]    fd [SUP];
  logic signed [NBITS-1:0] fv [SUP];
  logic signed [NBITS-1:0] fa [SUP];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected sums whenever the DUT presents a result, plus protocol checks
  bit prev_ready = 1'b0;
  bit prev_v     = 1'b0;
  bit prev_a     = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   lf;
    if (cyc > 0) begin
      if (matmul2_v_valid && matmul2_a_valid) check("valids_concurrent", 1, 0);
      if (prev_v && matmul2_v_valid) check("v_valid_one_cycle", 1, 0);
      if (prev_a && matmul2_a_valid) check("a_valid_one_cycle", 1, 0);
      if (matmul2_v_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_v_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("v_slot_kind", longint'(e.is_a), 0);
          check("valence_sum", longint'(matmul2_result), e.val);
        end
        if (lastfire_q.size() == 0) begin
          check("v_latency_missing_fire", 1, 0);
        end else begin
          lf = lastfire_q.pop_front();
          check("v_valid_latency", longint'(cyc), longint'(lf + 2));
        end
        check("ready_low_in_emit_v", longint'(din_ready), 0);
        check("ready_low_in_drain", longint'(prev_ready), 0);
      end
      if (matmul2_a_valid) begin
        check("a_follows_v", longint'(prev_v), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_a_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("a_slot_kind", longint'(e.is_a), 1);
          check("arousal_sum", longint'(matmul2_result), e.val);
        end
        check("ready_low_in_emit_a", longint'(din_ready), 0);
      end
      if (prev_a && rst) check("ready_back_after_emit", longint'(din_ready), 1);
      if (!matmul2_v_valid && !matmul2_a_valid) check("result_zero_idle", longint'(matmul2_result), 0);
      prev_ready = din_ready;
      prev_v     = matmul2_v_valid;
      prev_a     = matmul2_a_valid;
    end
  end

  // Drives one frame from fd/fa/fv; stops after nfire elements when aborting
  task automatic send_frame(input bit bubbles, input bit push, input int nfire);
    longint sv;
    longint sa;
    int     nb;
    int     wait_n;
    sv = 0;
    sa = 0;
    for (int i = 0; i < SUP; i++) begin
      vrom[i] = fv[i];
      arom[i] = fa[i];
      sv += longint'(fd[i]) * longint'(fv[i]);
      sa += longint'(fd[i]) * longint'(fa[i]);
    end
    if (push) begin
      exp_q.push_back('{is_a: 1'b0, val: sv});
      exp_q.push_back('{is_a: 1'b1, val: sa});
    end
    for (int i = 0; i < nfire; i++) begin
      nb = bubbles ? int'($urandom_range(0, 2)) : 0;
      for (int b = 0; b < nb; b++) begin
        din_valid = 1'b0;
        din = KW'($urandom);
        @(negedge clk);
        check("coef_addr_holds", longint'(coef_addr), longint'(i));
      end
      din       = fd[i];
      din_valid = 1'b1;
      wait_n    = 0;
      while (!din_ready && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      if (!din_ready) begin
        check("din_ready_timeout", 0, 1);
        return;
      end
      check("coef_addr_at_fire", longint'(coef_addr), longint'(i));
      if (push && i == SUP - 1) lastfire_q.push_back(cyc);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst       = 1'b0;
    din_valid = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check("rst_din_ready", longint'(din_ready), 0);
      check("rst_v_valid", longint'(matmul2_v_valid), 0);
      check("rst_a_valid", longint'(matmul2_a_valid), 0);
      check("rst_result", longint'(matmul2_result), 0);
      check("rst_coef_addr", longint'(coef_addr), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", longint'(din_ready), 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < SUP; i++) begin
      fd[i] = KW'(1);
      fv[i] = NBITS'(i + 1);
      fa[i] = -NBITS'(1);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < SUP; i++) begin
      fd[i] = KW'($urandom);
      fv[i] = NBITS'($urandom);
      fa[i] = NBITS'($urandom);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [KW-1:0] d_min;
    d_min = '0;
    d_min[KW-1] = 1'b1;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    for (int i = 0; i < SUP; i++) begin
      vrom[i] = '0;
      arom[i] = '0;
    end
    @(negedge clk);
    do_reset(3);

    // Basic frame
    load_basic();
    send_frame(1'b0, 1'b1, SUP);

    // Extremes: most-negative din against both coefficient extremes
    for (int i = 0; i < SUP; i++) begin
      fd[i] = d_min;
      fv[i] = {1'b1, {(NBITS - 1){1'b0}}};
      fa[i] = {1'b0, {(NBITS - 1){1'b1}}};
    end
    send_frame(1'b0, 1'b1, SUP);

    // Bubbles: same sums as basic
    load_basic();
    send_frame(1'b1, 1'b1, SUP);

    // Back-to-back with din_valid held high
    load_random();
    send_frame(1'b0, 1'b1, SUP);
    load_basic();
    send_frame(1'b0, 1'b1, SUP);
    din_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset mid-frame, then the basic frame again
    load_random();
    send_frame(1'b0, 1'b0, 2);
    do_reset(2);
    load_basic();
    send_frame(1'b0, 1'b1, SUP);

    // Random frames with random bubbles
    for (int f = 0; f < 8; f++) begin
      load_random();
      send_frame(bit'($urandom_range(0, 1)), 1'b1, SUP);
    end
    din_valid = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_drained", longint'(exp_q.size()), 0);
    check("fire_log_drained", longint'(lastfire_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
